// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline (PC, IF/ID, ID/EX, EX).
// Define PIPE_STALL_CTRL_PERF_EN to implement the stall_count/flush_count counters.
module pipe_stall_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MD_TIMEOUT   = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  IF_ID_rs,
   input  logic [4:0]  IF_ID_rt,
   input  logic        IF_ID_uses_rt,
   input  logic [4:0]  EX_ID_rt,
   input  logic        EX_ID_memory_read,
   input  logic        EX_mispredict,
   input  logic        ID_IF_jump,
   input  logic        EX_md_start,
   input  logic        EX_md_done,
   output logic        pc_enable,
   output logic        IF_enable,
   output logic        ID_enable,
   output logic        EX_enable,
   output logic        IF_flush,
   output logic        ID_flush,
   output logic        md_timeout,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {StRun, StMdWait, StFlush} state_e;

   localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);
   localparam logic [7:0] MdLast    = 8'(MD_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [3:0]  flush_cnt_q, flush_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        md_timeout_q, md_timeout_d;
   logic        front_en, ex_en, if_fl, id_fl;
   logic        stall_inc, flush_inc;
   logic        load_use;

   assign load_use = EX_ID_memory_read & (EX_ID_rt != 5'd0) &
                     ((EX_ID_rt == IF_ID_rs) | (IF_ID_uses_rt & (EX_ID_rt == IF_ID_rt)));

   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      md_timeout_d = md_timeout_q;
      front_en     = 1'b1;
      ex_en        = 1'b1;
      if_fl        = 1'b0;
      id_fl        = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      unique case (state_q)
         StRun: begin
            if (EX_mispredict) begin
               if_fl     = 1'b1;
               id_fl     = 1'b1;
               flush_inc = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  flush_cnt_d = FlushLoad;
                  state_d     = StFlush;
               end
            end else if (EX_md_start) begin
               wait_cnt_d = '0;
               // A single-cycle op that completes on entry never freezes the front end.
               if (!EX_md_done) begin
                  front_en = 1'b0;
                  ex_en    = 1'b0;
                  state_d  = StMdWait;
               end
            end else if (load_use) begin
               front_en  = 1'b0;
               stall_inc = 1'b1;
            end else if (ID_IF_jump) begin
               if_fl = 1'b1;
            end
         end
         StMdWait: begin
            stall_inc = 1'b1;
            if (EX_md_done) begin
               state_d = StRun;
            end else if (wait_cnt_q == MdLast) begin
               md_timeout_d = 1'b1;
               id_fl        = 1'b1;
               state_d      = StRun;
            end else begin
               front_en   = 1'b0;
               ex_en      = 1'b0;
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         StFlush: begin
            if_fl = 1'b1;
            id_fl = 1'b1;
            if (EX_mispredict) begin
               flush_cnt_d = FlushLoad;
               flush_inc   = 1'b1;
            end else if (flush_cnt_q == 4'd1) begin
               state_d = StRun;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StRun;
         flush_cnt_q  <= '0;
         wait_cnt_q   <= '0;
         md_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         md_timeout_q <= md_timeout_d;
      end
   end

   // Reset overrides every control output combinationally.
   assign pc_enable  = front_en & ~rst;
   assign IF_enable  = front_en & ~rst;
   assign ID_enable  = front_en & ~rst;
   assign EX_enable  = ex_en & ~rst;
   assign IF_flush   = if_fl & ~rst;
   assign ID_flush   = id_fl & ~rst;
   assign md_timeout = md_timeout_q;

`ifdef PIPE_STALL_CTRL_PERF_EN
   logic [15:0] stall_q, flush_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_inc && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
         if (flush_inc && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
      end
   end

   assign stall_count = stall_q;
   assign flush_count = flush_q;
`else
   logic unused_perf;
   assign unused_perf = stall_inc ^ flush_inc;
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline.
- Decides each cycle whether PC, IF/ID, ID/EX and EX advance, hold, bubble or flush.
- Sources: load-use hazards, EX-stage branch mispredicts, ID-stage jumps, and a multi-cycle EX unit (multiply/divide) that must freeze the front end until done.
- Replaces per-stage ad hoc hazard logic with one FSM feeding pc_enable, IF_enable, ID_enable and ID_flush.

Parameters:
FLUSH_CYCLES, 1, cycles IF/ID and ID/EX are flushed after a mispredict (1..15)
MD_TIMEOUT, 64, max cycles waited for md_done before forced abort (2..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
IF_ID_rs  input  5  rs field of instruction in ID
IF_ID_rt  input  5  rt field of instruction in ID
IF_ID_uses_rt  input  1  ID instruction reads rt as a source
EX_ID_rt  input  5  rt of instruction in EX
EX_ID_memory_read  input  1  EX instruction is a load
EX_mispredict  input  1  branch resolved in EX disagrees with prediction
ID_IF_jump  input  1  ID holds an unconditional jump
EX_md_start  input  1  multi-cycle op entered EX this cycle
EX_md_done  input  1  multi-cycle op result valid
pc_enable  output  1  PC may update
IF_enable  output  1  IF/ID register may load
ID_enable  output  1  0 = ID/EX receives bubble controls
EX_enable  output  1  EX/MEM register may load
IF_flush  output  1  clear IF/ID next edge
ID_flush  output  1  clear ID/EX next edge
md_timeout  output  1  sticky: multi-cycle op exceeded MD_TIMEOUT
stall_count  output  16  saturating count of stall cycles
flush_count  output  16  saturating count of mispredict flush events

Behaviour:
- State register: RUN, MD_WAIT, FLUSH. Enable/flush outputs are combinational from state and current inputs (same-cycle effect). Counters, md_timeout and state are registered.
- Reset (rst=1, async): state=RUN; flush counter=0; wait counter=0; md_timeout=0; stall_count=flush_count=0. While rst=1, all enables=0 and both flushes=0, overriding all else.
- load_use = EX_ID_memory_read & (EX_ID_rt!=0) & ((EX_ID_rt==IF_ID_rs) | (IF_ID_uses_rt & EX_ID_rt==IF_ID_rt)).
- RUN, priority highest first:
  1. EX_mispredict: pc/IF/ID/EX enables=1, IF_flush=ID_flush=1. flush_count++. If FLUSH_CYCLES>1, load counter=FLUSH_CYCLES-1 and go to FLUSH; else stay in RUN.
  2. EX_md_start: pc/IF/ID/EX enables=0, no flush. Wait counter=0. Go to MD_WAIT; if EX_md_done is also 1 in this cycle, stay in RUN with all enables=1.
  3. load_use: pc_enable=IF_enable=ID_enable=0, EX_enable=1 (one bubble). stall_count++. Stay in RUN; the hazard clears naturally next cycle.
  4. ID_IF_jump: all enables=1, IF_flush=1 (squash the fetched slot), ID_flush=0.
  5. Otherwise: all enables=1, flushes=0.
- MD_WAIT: all enables=0, flushes=0, stall_count++ each cycle.
  - EX_md_done=1: all enables=1 this cycle, go to RUN.
  - Wait counter reaches MD_TIMEOUT-1 without done: set md_timeout (sticky until rst), all enables=1, ID_flush=1, go to RUN.
  - EX_mispredict, load_use and ID_IF_jump are ignored in MD_WAIT.
- FLUSH: all enables=1, IF_flush=ID_flush=1. Counter decrements; go to RUN when counter==1. A new EX_mispredict in FLUSH reloads counter=FLUSH_CYCLES-1 and increments flush_count.
- Counters saturate at 16'hFFFF with no wrap.
- Reset asserted mid-MD_WAIT or mid-FLUSH: immediate return to RUN; the partially completed op is discarded.

Optional Feature:
PIPE_STALL_CTRL_PERF_EN
- Defined: stall_count and flush_count are implemented as specified.
- Undefined: both outputs are constant 0 and no counter flops are synthesised. All other behaviour is identical.

Test Plan:
- Reset: rst pulse mid-cycle -> all enables 0 immediately; after release with no hazards, all enables 1, md_timeout=0, counts 0.
- Load-use: EX_ID_memory_read=1, EX_ID_rt=5, IF_ID_rs=5 -> one cycle pc/IF/ID_enable=0, EX_enable=1, stall_count=1. Repeat with EX_ID_rt=0 -> no stall.
- Mispredict, FLUSH_CYCLES=3: pulse EX_mispredict -> IF_flush=ID_flush=1 for exactly 3 cycles, flush_count=1, then RUN.
- Multi-cycle: EX_md_start, EX_md_done 4 cycles later -> enables 0 for 4 cycles, then 1; stall_count=4; a mispredict during the wait is ignored.
- Timeout, MD_TIMEOUT=8: EX_md_start with no done -> after 8 cycles md_timeout=1 (stays 1), ID_flush pulse, return to RUN.
- Priority: EX_mispredict, load_use and ID_IF_jump together -> flush response only, stall_count unchanged. Jump alone -> IF_flush=1, ID_flush=0.
